sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one 16-bit-wide asynchronous SRAM between a CHR loader (boot mode),
//   the PPU and the CPU (run mode). Requesters use byte addresses; each access
//   is IDLE -> ACC1 -> ACC2 -> ACK. PPU has priority, but the CPU is forced
//   through after STARVE_MAX consecutive PPU grants while it waits.
//
// Ports
//   i_clk, i_rstn              clock, asynchronous active-low reset
//   i_ld_done                  loader finished; switches to run mode
//   i_ld_*                     loader SRAM bus, passed straight through in boot mode
//   i_ppu_req/addr             PPU read request (level) and byte address
//   o_ppu_ack/rdata            PPU completion pulse and read byte
//   i_cpu_req/we/addr/wdata    CPU request (level), direction, address, write byte
//   o_cpu_ack/rdata            CPU completion pulse and read byte
//   o_sram_*                   SRAM bus
//   i_sram_rdata               SRAM read data
module sram_arbiter #(
    parameter int STARVE_MAX = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_ld_done,
    input  logic [19:0] i_ld_addr,
    input  logic [15:0] i_ld_wdata,
    input  logic        i_ld_oe_n,
    input  logic        i_ld_we_n,
    input  logic        i_ld_ub_n,
    input  logic        i_ld_lb_n,
    input  logic        i_ppu_req,
    input  logic [19:0] i_ppu_addr,
    output logic        o_ppu_ack,
    output logic [7:0]  o_ppu_rdata,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [19:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    output logic [19:0] o_sram_addr,
    output logic [15:0] o_sram_wdata,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    output logic        o_sram_ub_n,
    output logic        o_sram_lb_n,
    input  logic [15:0] i_sram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_ACK} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_run;
    logic [SW-1:0]   r_starve;
    logic            r_gnt_cpu, r_we, r_hi;
    logic [19:0]     r_addr;
    logic [7:0]      r_wbyte;
    logic            r_oe_n, r_we_n, r_ub_n, r_lb_n;
    logic [15:0]     r_wdata;
    logic            r_ppu_ack, r_cpu_ack;
    logic [7:0]      r_ppu_rdata, r_cpu_rdata;

    logic            w_grant, w_gnt_cpu;
    logic            w_we_nxt, w_hi_nxt;
    logic [19:0]     w_req_addr, w_addr_nxt;
    logic [7:0]      w_wbyte_nxt, w_rbyte;
    logic            w_oe_n, w_we_n, w_ub_n, w_lb_n;
    logic [15:0]     w_wdata;

    // Byte address -> 16-bit word address; bit 3 picks the lane, so the
    // remaining bits are packed with a leading zero.
    function automatic logic [19:0] f_word_addr(input logic [19:0] a);
        return {1'b0, a[19:4], a[2:0]};
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_cpu   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_run && (i_ppu_req || i_cpu_req)) begin
                    w_grant     = 1'b1;
                    w_gnt_cpu   = i_cpu_req && (!i_ppu_req || r_starve == STARVE_LIM);
                    w_state_nxt = S_ACC1;
                end
            end
            S_ACC1:  w_state_nxt = S_ACC2;
            S_ACC2:  w_state_nxt = S_ACK;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Values latched at grant time; the registered bus below is derived from
    // them together with the next state so the strobes line up with the state.
    always_comb begin
        w_req_addr  = w_gnt_cpu ? i_cpu_addr : i_ppu_addr;
        w_we_nxt    = w_grant ? (w_gnt_cpu && i_cpu_we) : r_we;
        w_hi_nxt    = w_grant ? w_req_addr[3] : r_hi;
        w_addr_nxt  = w_grant ? f_word_addr(w_req_addr) : r_addr;
        w_wbyte_nxt = w_grant ? i_cpu_wdata : r_wbyte;
    end

    always_comb begin
        w_oe_n  = 1'b1;
        w_we_n  = 1'b1;
        w_ub_n  = 1'b1;
        w_lb_n  = 1'b1;
        w_wdata = 16'h0000;
        if (w_state_nxt == S_ACC1 || w_state_nxt == S_ACC2) begin
            w_ub_n = !w_hi_nxt;
            w_lb_n = w_hi_nxt;
            if (w_we_nxt) begin
                w_wdata = w_hi_nxt ? {w_wbyte_nxt, 8'h00} : {8'h00, w_wbyte_nxt};
                // Write pulse only in the second cycle: address/data settle first.
                w_we_n  = (w_state_nxt != S_ACC2);
            end else begin
                w_oe_n = 1'b0;
            end
        end
    end

    assign w_rbyte = r_hi ? i_sram_rdata[15:8] : i_sram_rdata[7:0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_starve    <= '0;
            r_gnt_cpu   <= 1'b0;
            r_we        <= 1'b0;
            r_hi        <= 1'b0;
            r_addr      <= 20'h00000;
            r_wbyte     <= 8'h00;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_wdata     <= 16'h0000;
            r_ppu_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ppu_rdata <= 8'h00;
            r_cpu_rdata <= 8'h00;
        end else begin
            if (!r_run && i_ld_done && r_state == S_IDLE)
                r_run <= 1'b1;
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_hi    <= w_hi_nxt;
            r_addr  <= w_addr_nxt;
            r_wbyte <= w_wbyte_nxt;
            if (w_grant) begin
                r_gnt_cpu <= w_gnt_cpu;
                if (w_gnt_cpu)
                    r_starve <= '0;
                else if (i_cpu_req && r_starve != STARVE_LIM)
                    r_starve <= r_starve + 1'b1;
            end
            r_oe_n    <= w_oe_n;
            r_we_n    <= w_we_n;
            r_ub_n    <= w_ub_n;
            r_lb_n    <= w_lb_n;
            r_wdata   <= w_wdata;
            r_ppu_ack <= (w_state_nxt == S_ACK) && !r_gnt_cpu;
            r_cpu_ack <= (w_state_nxt == S_ACK) && r_gnt_cpu;
            if (r_state == S_ACC2 && !r_we) begin
                if (r_gnt_cpu) r_cpu_rdata <= w_rbyte;
                else           r_ppu_rdata <= w_rbyte;
            end
        end
    end

    // Boot mode hands the SRAM to the loader combinationally.
    assign o_sram_addr  = r_run ? r_addr  : i_ld_addr;
    assign o_sram_wdata = r_run ? r_wdata : i_ld_wdata;
    assign o_sram_oe_n  = r_run ? r_oe_n  : i_ld_oe_n;
    assign o_sram_we_n  = r_run ? r_we_n  : i_ld_we_n;
    assign o_sram_ub_n  = r_run ? r_ub_n  : i_ld_ub_n;
    assign o_sram_lb_n  = r_run ? r_lb_n  : i_ld_lb_n;

    assign o_ppu_ack   = r_ppu_ack;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_ppu_rdata = r_ppu_rdata;
    assign o_cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ld_done;
    logic [19:0] ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_oe_n, ld_we_n, ld_ub_n, ld_lb_n;
    logic        ppu_req;
    logic [19:0] ppu_addr;
    logic        ppu_ack;
    logic [7:0]  ppu_rdata;
    logic        cpu_req, cpu_we;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] sram_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_MAX(2)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_ld_done(ld_done),
        .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata), .i_ld_oe_n(ld_oe_n),
        .i_ld_we_n(ld_we_n), .i_ld_ub_n(ld_ub_n), .i_ld_lb_n(ld_lb_n),
        .i_ppu_req(ppu_req), .i_ppu_addr(ppu_addr),
        .o_ppu_ack(ppu_ack), .o_ppu_rdata(ppu_rdata),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata),
        .o_sram_oe_n(sram_oe_n), .o_sram_we_n(sram_we_n),
        .o_sram_ub_n(sram_ub_n), .o_sram_lb_n(sram_lb_n),
        .i_sram_rdata(sram_rdata)
    );

    typedef struct packed {
        logic       cpu;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_pass(input string nm);
        chk(nm, 64'({sram_addr, sram_wdata, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}),
                64'({ld_addr, ld_wdata, ld_oe_n, ld_we_n, ld_ub_n, ld_lb_n}));
    endtask

    // Scoreboard monitor: every ack pops one expected grant.
    always @(negedge clk) begin
        if (ppu_ack || cpu_ack) begin
            chk("ack_overlap", 64'(ppu_ack & cpu_ack), 64'(0));
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'({ppu_ack, cpu_ack}), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("grantee", 64'({ppu_ack, cpu_ack}), e.cpu ? 64'(2'b01) : 64'(2'b10));
                chk(e.cpu ? "cpu_rdata" : "ppu_rdata", 64'(e.cpu ? cpu_rdata : ppu_rdata), 64'(e.rd));
            end
        end
    end

    // One requester transaction: drop req for a full cycle from the ack cycle.
    task automatic access(input logic cpu, input logic we, input logic [19:0] a, input logic [7:0] wd);
        logic got;
        if (cpu) begin
            cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        end else begin
            ppu_addr = a; ppu_req = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            got = cpu ? cpu_ack : ppu_ack;
        end
        chk(cpu ? "cpu_ack_wait" : "ppu_ack_wait", 64'(got), 64'(1));
        if (cpu) cpu_req = 1'b0;
        else     ppu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges, oe_cyc, k;
        logic got;

        rstn = 1'b0; ld_done = 1'b0;
        ld_addr = 20'hA5A5A; ld_wdata = 16'h1234;
        ld_oe_n = 1'b0; ld_we_n = 1'b1; ld_ub_n = 1'b0; ld_lb_n = 1'b1;
        ppu_req = 1'b0; ppu_addr = 20'h0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 20'h0; cpu_wdata = 8'h00; sram_rdata = 16'hAB12;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acks", 64'({ppu_ack, cpu_ack}), 64'(0));
        chk("rst_rdata", 64'({ppu_rdata, cpu_rdata}), 64'(0));
        check_pass("rst_pass");
        rstn = 1'b1;

        // Boot: loader owns the bus, PPU request waits.
        ppu_addr = 20'h00008; ppu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_addr  = 20'h10000 + 20'(i * 37);
            ld_wdata = 16'hC000 ^ 16'(i * 257);
            ld_oe_n  = i[0]; ld_we_n = !i[0]; ld_ub_n = i[1]; ld_lb_n = !i[1];
            #1;
            check_pass("boot_pass");
            chk("boot_no_ack", 64'({ppu_ack, cpu_ack}), 64'(0));
            @(posedge clk); #1;
        end

        // Leave boot; ack lands in the fifth cycle counting the ld_done cycle.
        sb.push_back('{cpu: 1'b0, rd: 8'hAB});
        ld_done = 1'b1;
        edges = 0; oe_cyc = 0; got = 1'b0;
        while (!got && edges < 12) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (!sram_oe_n) begin
                oe_cyc++;
                chk("ppu_rd_addr", 64'(sram_addr), 64'(20'h00000));
                chk("ppu_rd_lanes", 64'({sram_ub_n, sram_lb_n, sram_we_n}), 64'(3'b011));
            end
            got = ppu_ack;
        end
        chk("boot_ack_latency", 64'(edges), 64'(4));
        chk("ppu_oe_cycles", 64'(oe_cyc), 64'(2));
        chk("ack_bus_idle", 64'({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_wdata}),
            64'({4'b1111, 16'h0000}));
        ppu_req = 1'b0;
        @(posedge clk); #1;
        ld_oe_n = 1'b0; ld_addr = 20'hFFFFF;
        #1;
        chk("run_ignores_ld", 64'({sram_oe_n, sram_addr}), 64'({1'b1, 20'h00000}));

        // CPU write to byte 0x13: word 1 offset 3, lower lane.
        sb.push_back('{cpu: 1'b1, rd: 8'h00});
        cpu_we = 1'b1; cpu_addr = 20'h00013; cpu_wdata = 8'h5C; cpu_req = 1'b1;
        k = 0; got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (!sram_lb_n) begin
                chk("cpu_wr_addr", 64'(sram_addr), 64'(20'h0000B));
                chk("cpu_wr_data", 64'(sram_wdata), 64'(16'h005C));
                chk("cpu_wr_oe_ub", 64'({sram_oe_n, sram_ub_n}), 64'(2'b11));
                chk("cpu_wr_we_n", 64'(sram_we_n), (k == 0) ? 64'(1) : 64'(0));
                k++;
            end
            got = cpu_ack;
        end
        chk("cpu_wr_ack", 64'(got), 64'(1));
        chk("cpu_wr_cycles", 64'(k), 64'(2));
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("idle_addr_hold", 64'({sram_addr, sram_wdata, sram_we_n}), 64'({20'h0000B, 16'h0000, 1'b1}));

        // CPU read lower lane, then a write that must leave rdata alone.
        sb.push_back('{cpu: 1'b1, rd: 8'h12});
        access(1'b1, 1'b0, 20'h00000, 8'h00);
        sb.push_back('{cpu: 1'b1, rd: 8'h12});
        access(1'b1, 1'b1, 20'h00003, 8'h77);

        // Simultaneous first requests: PPU then CPU.
        sb.push_back('{cpu: 1'b0, rd: 8'hAB});
        sb.push_back('{cpu: 1'b1, rd: 8'h12});
        fork
            access(1'b0, 1'b0, 20'h00008, 8'h00);
            access(1'b1, 1'b0, 20'h00000, 8'h00);
        join

        // Both keep requesting: PPU, PPU, CPU repeating.
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{cpu: 1'b0, rd: 8'hAB});
            sb.push_back('{cpu: 1'b0, rd: 8'hAB});
            sb.push_back('{cpu: 1'b1, rd: 8'h12});
        end
        fork
            begin repeat (4) access(1'b0, 1'b0, 20'h00008, 8'h00); end
            begin repeat (2) access(1'b1, 1'b0, 20'h00000, 8'h00); end
        join

        // Reset in the write-pulse cycle aborts the access with no ack.
        ld_we_n = 1'b1;
        cpu_we = 1'b1; cpu_addr = 20'h00013; cpu_wdata = 8'h5C; cpu_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = !sram_we_n;
        end
        chk("abort_reach_acc2", 64'(got), 64'(1));
        rstn = 1'b0;
        #1;
        chk("abort_we_n", 64'(sram_we_n), 64'(1));
        check_pass("abort_pass");
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_rdata", 64'({ppu_rdata, cpu_rdata}), 64'(0));
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
